// File: rtl/soc_bus_pkg.sv
// Shared widths, wait-FSM encodings and a packed-parameter field
// extractor for the 6502 SoC bus controller.
package soc_bus_pkg;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WW = 4;
    localparam int MAXREG = 8;
    localparam int PW = MAXREG * AW;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    // Field k of width w (w <= 16) from a zero-extended packed vector
    function automatic logic [AW-1:0] get_field(
        input logic [PW-1:0] v,
        input int            k,
        input int            w
    );
        logic [PW-1:0] s;
        s = v >> (k * w);
        return s[AW-1:0] & AW'((32'h1 << w) - 32'h1);
    endfunction

endpackage

// File: rtl/soc_bus_ctrl_clk_ce_gen.sv
// CPU clock-enable divider and the post-reset CPU reset sequencer.
// cpu_reset is held for RESET_DEL+1 cpu_ce ticks after reset_n rises.
module clk_ce_gen #(
    parameter int CLKDIV    = 50000,
    parameter int RESET_DEL = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic cpu_ce,
    output logic cpu_reset
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int RW = $clog2(RESET_DEL + 1) + 1;
    localparam logic [CW-1:0] DIV_TOP = CW'(CLKDIV - 1);
    localparam logic [RW-1:0] DEL_TOP = RW'(RESET_DEL);

    logic [CW-1:0] r_div;
    logic [RW-1:0] r_rst_cnt;
    logic          r_cpu_reset;
    logic          w_ce;

    // With CLKDIV=1 the counter never leaves 0, so the enable is constant
    assign w_ce = (r_div == DIV_TOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (w_ce) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_cnt   <= '0;
            r_cpu_reset <= 1'b1;
        end else if (w_ce && r_cpu_reset) begin
            if (r_rst_cnt == DEL_TOP) begin
                r_cpu_reset <= 1'b0;
            end else begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
        end
    end

    assign cpu_ce    = w_ce;
    assign cpu_reset = r_cpu_reset;

endmodule

// File: rtl/soc_bus_ctrl.sv
// 6502 SoC bus controller: region decode, RDY wait states,
// registered read select, read-data mux and unmapped-access flag.
module soc_bus_ctrl
    import soc_bus_pkg::*;
#(
    parameter int NREG      = 4,
    parameter int CLKDIV    = 50000,
    parameter int RESET_DEL = 2,
    parameter logic [NREG*16-1:0] BASE =
        {16'hCC20, 16'hCC10, 16'hFFFC, 16'hAA00},
    parameter logic [NREG*16-1:0] MASK =
        {16'hFFFE, 16'hFFFF, 16'hFFFC, 16'hFE00},
    parameter logic [NREG*4-1:0]  WAIT =
        {4'd2, 4'd0, 4'd0, 4'd1}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     ab,
    input  logic              we,
    input  logic [NREG*DW-1:0] di_bus,
    input  logic              err_clr,
    output logic              cpu_ce,
    output logic              cpu_reset,
    output logic              rdy,
    output logic [NREG-1:0]   cs,
    output logic [NREG-1:0]   rd_sel,
    output logic [DW-1:0]     di,
    output logic              bus_err
);

    localparam logic [PW-1:0] BASE_X = PW'(BASE);
    localparam logic [PW-1:0] MASK_X = PW'(MASK);
    localparam logic [PW-1:0] WAIT_X = PW'(WAIT);

    logic            w_ce;
    logic            w_cpu_reset;
    logic [NREG-1:0] w_cs;
    logic [WW-1:0]   w_wait;
    logic            w_need_wait;
    logic            r_state;
    logic            w_state_nxt;
    logic [WW-1:0]   r_wcnt;
    logic [WW-1:0]   w_wcnt_nxt;
    logic            w_rdy;
    logic [NREG-1:0] r_rd_sel;
    logic            r_bus_err;
    logic [DW-1:0]   w_di;

    clk_ce_gen #(
        .CLKDIV    (CLKDIV),
        .RESET_DEL (RESET_DEL)
    ) u_ce (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_ce    (w_ce),
        .cpu_reset (w_cpu_reset)
    );

    // Scan high to low so the lowest-index hit wins on overlap
    always_comb begin
        w_cs   = '0;
        w_wait = '0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if ((ab & get_field(MASK_X, k, AW)) == get_field(BASE_X, k, AW)) begin
                w_cs    = '0;
                w_cs[k] = 1'b1;
                w_wait  = WW'(get_field(WAIT_X, k, WW));
            end
        end
    end

    assign w_need_wait = (|w_cs) && (w_wait != '0) && !w_cpu_reset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        if (w_ce) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_need_wait) begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_nxt  = w_wait - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt != '0) begin
                        w_wcnt_nxt = r_wcnt - 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rdy = 1'b1;
        unique case (r_state)
            S_IDLE:  w_rdy = !w_need_wait;
            S_WAIT:  w_rdy = (r_wcnt == '0);
            default: w_rdy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_sel <= '0;
        end else if (w_ce && w_rdy) begin
            r_rd_sel <= w_cs & {NREG{~we}};
        end
    end

    // A miss in the same cycle takes priority over err_clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_err <= 1'b0;
        end else if (w_ce && w_rdy && (w_cs == '0) && !w_cpu_reset) begin
            r_bus_err <= 1'b1;
        end else if (err_clr) begin
            r_bus_err <= 1'b0;
        end
    end

    always_comb begin
        w_di = '0;
        for (int k = 0; k < NREG; k++) begin
            w_di = w_di | (di_bus[k*DW +: DW] & {DW{r_rd_sel[k]}});
        end
    end

    assign cpu_ce    = w_ce;
    assign cpu_reset = w_cpu_reset;
    assign rdy       = w_rdy;
    assign cs        = w_cs;
    assign rd_sel    = r_rd_sel;
    assign di        = w_di;
    assign bus_err   = r_bus_err;

endmodule
